pe_os_mac: RTL

- Output-stationary systolic processing element, next generation of the single-cycle INT8 multiply-accumulate PE.
- Operands enter from the west (A) and north (B) with valid bits and are forwarded east and south after one register stage.
- Each PE accumulates a local dot product through a 2-stage multiply/accumulate pipeline, with per-pair signed/unsigned mode.
- Finished results are double-buffered and drained down the column through a C shift chain, so the next tile can accumulate while the previous one drains.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_os_mac_if.sv | 32 +++
 rtl/pe_mult_stage.sv | 41 ++++
 rtl/pe_os_mac.sv | 94 +++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared width defaults, stage-1 control bits and saturation bounds for pe_os_mac.
package pe_pkg;
   localparam int OPERAND_WIDTH_DEF    = 8;
   localparam int ACCUMULATE_WIDTH_DEF = 24;
   typedef struct packed {
      logic p_valid;
      logic p_last;
      logic p_signed;
   } s1_ctl_t;
   function automatic logic [63:0] sat_max(input int unsigned aw, input logic sgn);
      return sgn ? (64'd1 << (aw - 1)) - 64'd1 : (64'd1 << aw) - 64'd1;
   endfunction
   function automatic logic [63:0] sat_min(input int unsigned aw, input logic sgn);
      return sgn ? ~((64'd1 << (aw - 1)) - 64'd1) : 64'd0;
   endfunction
endpackage

// File: rtl/pe_os_mac_if.sv
// pe_os_mac_if: operand forwarding and result-chain signals of one PE.
// PE_OS_MAC_SAT_EN adds the sticky sat_o flag.
interface pe_os_mac_if #(
   parameter int OPERAND_WIDTH    = pe_pkg::OPERAND_WIDTH_DEF,
   parameter int ACCUMULATE_WIDTH = pe_pkg::ACCUMULATE_WIDTH_DEF
);
   logic [OPERAND_WIDTH-1:0]    a_i, b_i, a_o, b_o;
   logic                        a_valid_i, a_last_i, signed_i, b_valid_i;
   logic                        a_valid_o, a_last_o, signed_o, b_valid_o;
   logic                        drain_i, c_valid_i, c_valid_o, res_pending_o, err_o;
   logic [ACCUMULATE_WIDTH-1:0] c_i, c_o;
`ifdef PE_OS_MAC_SAT_EN
   logic sat_o;
   modport master (
      output a_i, a_valid_i, a_last_i, signed_i, b_i, b_valid_i, drain_i, c_i, c_valid_i,
      input  a_o, a_valid_o, a_last_o, signed_o, b_o, b_valid_o, c_o, c_valid_o, res_pending_o, err_o, sat_o
   );
   modport slave (
      input  a_i, a_valid_i, a_last_i, signed_i, b_i, b_valid_i, drain_i, c_i, c_valid_i,
      output a_o, a_valid_o, a_last_o, signed_o, b_o, b_valid_o, c_o, c_valid_o, res_pending_o, err_o, sat_o
   );
`else
   modport master (
      output a_i, a_valid_i, a_last_i, signed_i, b_i, b_valid_i, drain_i, c_i, c_valid_i,
      input  a_o, a_valid_o, a_last_o, signed_o, b_o, b_valid_o, c_o, c_valid_o, res_pending_o, err_o
   );
   modport slave (
      input  a_i, a_valid_i, a_last_i, signed_i, b_i, b_valid_i, drain_i, c_i, c_valid_i,
      output a_o, a_valid_o, a_last_o, signed_o, b_o, b_valid_o, c_o, c_valid_o, res_pending_o, err_o
   );
`endif
endinterface

// File: rtl/pe_mult_stage.sv
// pe_mult_stage: signed/unsigned operand multiplier with its stage-1 register.
module pe_mult_stage
   import pe_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF
) (
   input  logic                         clk_i,
   input  logic                         reset,
   input  logic [OPERAND_WIDTH-1:0]     a_i,
   input  logic [OPERAND_WIDTH-1:0]     b_i,
   input  logic                         a_valid_i,
   input  logic                         b_valid_i,
   input  logic                         a_last_i,
   input  logic                         signed_i,
   output logic [2*OPERAND_WIDTH-1:0]   p_o,
   output s1_ctl_t                      ctl_o
);
   localparam int OW = OPERAND_WIDTH;
   logic [2*OW-1:0] a_x, b_x, p_d, p_q;
   s1_ctl_t ctl_d, ctl_q;
   logic fire;
   // One multiplier serves both modes: the low 2*OW bits of the extended product are exact.
   always_comb begin
      fire  = a_valid_i & b_valid_i;
      a_x   = {{OW{signed_i & a_i[OW-1]}}, a_i};
      b_x   = {{OW{signed_i & b_i[OW-1]}}, b_i};
      p_d   = a_x * b_x;
      ctl_d = '{p_valid: fire, p_last: a_last_i & fire, p_signed: signed_i};
   end
   always_ff @(posedge clk_i) begin
      if (reset) begin
         p_q   <= '0;
         ctl_q <= '0;
      end else begin
         p_q   <= p_d;
         ctl_q <= ctl_d;
      end
   end
   assign p_o   = p_q;
   assign ctl_o = ctl_q;
endmodule

// File: rtl/pe_os_mac.sv
// pe_os_mac: output-stationary MAC PE with double-buffered result drained down a C chain.
// Define PE_OS_MAC_SAT_EN for saturating accumulation and the sticky sat_o flag.
module pe_os_mac
   import pe_pkg::*;
#(
   parameter int OPERAND_WIDTH    = OPERAND_WIDTH_DEF,
   parameter int ACCUMULATE_WIDTH = ACCUMULATE_WIDTH_DEF
) (
   input logic        clk_i,
   input logic        reset,
   pe_os_mac_if.slave bus
);
   localparam int OW = OPERAND_WIDTH;
   localparam int AW = ACCUMULATE_WIDTH;
   localparam int FW = 2 * OW + 4;
   if (AW < 2 * OW) begin : g_width_chk
      $error("pe_os_mac: ACCUMULATE_WIDTH must be >= 2*OPERAND_WIDTH");
   end
   logic [2*OW-1:0] p;
   s1_ctl_t ctl;
   logic [FW-1:0] fwd_d, fwd_q;
   logic [AW-1:0] ext, base, nxt, acc_d, acc_q, res_d, res_q, c_d, c_q;
   logic first_d, first_q, pend_d, pend_q, err_d, err_q, cv_d, cv_q, latch;
`ifdef PE_OS_MAC_SAT_EN
   if (AW > 64) begin : g_sat_width_chk
      $error("pe_os_mac: saturation supports ACCUMULATE_WIDTH <= 64");
   end
   logic [AW:0] sum;
   logic ovf, sat_d, sat_q;
`endif
   pe_mult_stage #(.OPERAND_WIDTH(OW)) u_mult (
      .clk_i, .reset,
      .a_i(bus.a_i), .b_i(bus.b_i), .a_valid_i(bus.a_valid_i), .b_valid_i(bus.b_valid_i),
      .a_last_i(bus.a_last_i), .signed_i(bus.signed_i), .p_o(p), .ctl_o(ctl)
   );
   always_comb begin
      fwd_d = {bus.a_i, bus.a_valid_i, bus.a_last_i, bus.signed_i, bus.b_i, bus.b_valid_i};
      ext   = ctl.p_signed ? AW'($signed(p)) : AW'(p);
      base  = first_q ? '0 : acc_q;
`ifdef PE_OS_MAC_SAT_EN
      sum   = {1'b0, base} + {1'b0, ext};
      ovf   = ctl.p_signed ? (base[AW-1] == ext[AW-1]) && (sum[AW-1] != base[AW-1]) : sum[AW];
      nxt   = !ovf ? sum[AW-1:0] : !ctl.p_signed ? AW'(sat_max(AW, 1'b0)) :
              ext[AW-1] ? AW'(sat_min(AW, 1'b1)) : AW'(sat_max(AW, 1'b1));
      sat_d = sat_q | (ctl.p_valid & ovf);
`else
      nxt   = base + ext;
`endif
      latch   = ctl.p_valid & ctl.p_last;
      acc_d   = ctl.p_valid ? nxt : acc_q;
      first_d = ctl.p_valid ? ctl.p_last : first_q;
      res_d   = latch ? nxt : res_q;
      // Drain reads the old res/pending, so a result latched in the same edge stays pending.
      c_d     = !bus.drain_i ? c_q : pend_q ? res_q : bus.c_i;
      cv_d    = bus.drain_i & (pend_q | bus.c_valid_i);
      pend_d  = latch | (pend_q & ~bus.drain_i);
      err_d   = err_q | (latch & pend_q & ~bus.drain_i);
   end
   always_ff @(posedge clk_i) begin
      if (reset) begin
         fwd_q   <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         c_q     <= '0;
         first_q <= 1'b1;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         cv_q    <= 1'b0;
`ifdef PE_OS_MAC_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         fwd_q   <= fwd_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         c_q     <= c_d;
         first_q <= first_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         cv_q    <= cv_d;
`ifdef PE_OS_MAC_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end
   assign {bus.a_o, bus.a_valid_o, bus.a_last_o, bus.signed_o, bus.b_o, bus.b_valid_o} = fwd_q;
   assign bus.c_o           = c_q;
   assign bus.c_valid_o     = cv_q;
   assign bus.res_pending_o = pend_q;
   assign bus.err_o         = err_q;
`ifdef PE_OS_MAC_SAT_EN
   assign bus.sat_o         = sat_q;
`endif
endmodule
